dm_frame_sequencer: RTL

- Frame-level controller for the multichannel delta modulator.
- Accepts one frame of CHANNELS time-multiplexed ADC samples per start request and issues them to the modulator as single-cycle enables.
- Tags the returning spikes with their channel index and posts them as address-event words into an internal event FIFO with valid/ready output.
- Applies backpressure to the sample stream so the event FIFO can never overflow.

---
 rtl/dm_frame_sequencer_if.sv | 44 ++++
 rtl/dm_frame_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/dm_frame_sequencer_if.sv
// Sample stream, delta-modulator and event-FIFO signals of dm_frame_sequencer.
// ev_marker exists only when DM_FRAME_SEQUENCER_MARKER_EN is defined.
interface dm_frame_sequencer_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 16
);
  localparam int CW = $clog2(CHANNELS);

  logic                    s_valid;
  logic                    s_ready;
  logic signed [WIDTH-1:0] s_data;
  logic                    s_last;
  logic                    dm_en;
  logic signed [WIDTH-1:0] dm_samples;
  logic                    dm_pos_spike;
  logic                    dm_neg_spike;
  logic                    dm_valid;
  logic                    ev_valid;
  logic                    ev_ready;
  logic [CW-1:0]           ev_chan;
  logic                    ev_pol;

`ifdef DM_FRAME_SEQUENCER_MARKER_EN
  logic                    ev_marker;

  modport master (
    input  s_valid, s_data, s_last, dm_pos_spike, dm_neg_spike, dm_valid, ev_ready,
    output s_ready, dm_en, dm_samples, ev_valid, ev_chan, ev_pol, ev_marker
  );
  modport slave (
    output s_valid, s_data, s_last, dm_pos_spike, dm_neg_spike, dm_valid, ev_ready,
    input  s_ready, dm_en, dm_samples, ev_valid, ev_chan, ev_pol, ev_marker
  );
`else
  modport master (
    input  s_valid, s_data, s_last, dm_pos_spike, dm_neg_spike, dm_valid, ev_ready,
    output s_ready, dm_en, dm_samples, ev_valid, ev_chan, ev_pol
  );
  modport slave (
    output s_valid, s_data, s_last, dm_pos_spike, dm_neg_spike, dm_valid, ev_ready,
    input  s_ready, dm_en, dm_samples, ev_valid, ev_chan, ev_pol
  );
`endif
endinterface

// File: rtl/dm_frame_sequencer.sv
// Frame controller for the delta modulator: issues CHANNELS samples, tags spikes into an event FIFO.
// s_ready is credit-gated so the FIFO never overflows; optional end-of-frame marker via DM_FRAME_SEQUENCER_MARKER_EN.
module dm_frame_sequencer #(
  parameter int CHANNELS   = 16,
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CW         = $clog2(CHANNELS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  dm_frame_sequencer_if.master bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic [CW:0]          spike_cnt,
  output logic                 err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
`ifdef DM_FRAME_SEQUENCER_MARKER_EN
  localparam int EW = CW + 2;
`else
  localparam int EW = CW + 1;
`endif
  localparam logic [NW:0]   DEPTH_L = (NW+1)'(FIFO_DEPTH);
  localparam logic [NW-1:0] FULL_L  = NW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state;
  logic [CW-1:0]           chan;
  logic [CW:0]             frame_cnt;
  logic [1:0]              tag_v;
  logic [CW-1:0]           tag_c0, tag_c1;
  logic [1:0]              inflight, inflight_nxt;
  logic [EW-1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [NW-1:0]           fifo_count;
  logic [NW:0]             credit_sum;
  logic [EW-1:0]           push_dat, head;
  logic                    xfer, result, spike, push, pop, drained, start_ok, err_set;
  logic signed [WIDTH-1:0] beat;

  assign xfer           = bus.s_valid && bus.s_ready;
  assign beat           = bus.s_data;
  assign bus.dm_en      = xfer;
  assign bus.dm_samples = xfer ? beat : '0;

  assign credit_sum   = {1'b0, fifo_count} + {{(NW-1){1'b0}}, inflight};
  assign inflight_nxt = inflight + {1'b0, xfer} - {1'b0, tag_v[1]};

  // Stage 1 of the tag pipe lines up with the modulator's 2-cycle result strobe.
  assign result = tag_v[1] && bus.dm_valid;
  assign spike  = result && (bus.dm_pos_spike || bus.dm_neg_spike);

`ifdef DM_FRAME_SEQUENCER_MARKER_EN
  assign bus.s_ready = (state == RUN) && (credit_sum + (NW+1)'(1) < DEPTH_L);
  assign drained     = (state == DRAIN) && (inflight == 2'd0) && (fifo_count != FULL_L);
  assign push        = spike || drained;
  assign push_dat    = drained ? {LAST_CH, 1'b0, 1'b1} : {tag_c1, bus.dm_pos_spike, 1'b0};
  assign frame_done  = drained;
`else
  logic done_q;

  assign bus.s_ready = (state == RUN) && (credit_sum < DEPTH_L);
  // Finish as the last tag retires so frame_done lands 3 cycles after the last beat.
  assign drained     = (state == DRAIN) && (inflight_nxt == 2'd0);
  assign push        = spike;
  assign push_dat    = {tag_c1, bus.dm_pos_spike};
  assign frame_done  = done_q;
`endif

  assign head         = mem[rd_ptr];
  assign bus.ev_valid = (fifo_count != '0);
  assign bus.ev_chan  = bus.ev_valid ? head[EW-1 -: CW] : '0;
  assign bus.ev_pol   = bus.ev_valid && head[EW-CW-1];
`ifdef DM_FRAME_SEQUENCER_MARKER_EN
  assign bus.ev_marker = bus.ev_valid && head[0];
`endif
  assign pop = bus.ev_valid && bus.ev_ready;

  assign busy     = (state != IDLE);
  assign start_ok = (state == IDLE) && start && !frame_done;
  assign err_set  = (bus.dm_valid && !tag_v[1]) || (tag_v[1] && !bus.dm_valid) ||
                    (result && bus.dm_pos_spike && bus.dm_neg_spike) ||
                    (xfer && (bus.s_last != (chan == LAST_CH)));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      chan       <= '0;
      frame_cnt  <= '0;
      tag_v      <= '0;
      tag_c0     <= '0;
      tag_c1     <= '0;
      inflight   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      spike_cnt  <= '0;
      err        <= 1'b0;
`ifndef DM_FRAME_SEQUENCER_MARKER_EN
      done_q     <= 1'b0;
`endif
    end else begin
      tag_v      <= {tag_v[0], xfer};
      tag_c0     <= chan;
      tag_c1     <= tag_c0;
      inflight   <= inflight_nxt;
      err        <= (err && !start_ok) || err_set;
      fifo_count <= fifo_count + NW'(push) - NW'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
`ifndef DM_FRAME_SEQUENCER_MARKER_EN
      done_q     <= drained;
`endif
      if (start_ok)   frame_cnt <= '0;
      else if (spike) frame_cnt <= frame_cnt + (CW+1)'(1);

      case (state)
        IDLE: begin
          if (start_ok) begin
            state <= RUN;
            chan  <= '0;
          end
        end
        RUN: begin
          if (xfer) begin
            chan <= chan + CW'(1);
            if (chan == LAST_CH) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drained) begin
            state     <= IDLE;
            spike_cnt <= frame_cnt + {{CW{1'b0}}, spike};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
